// File: rtl/cpu_lut_slave_if.sv
// CPU bus bundle for the VPI lookup-table slave: Intel (Rd/Wr/Rdy) or
// Motorola (DS/RW/Dtack) signalling selected by BusMode.
interface cpu_lut_slave_if #(
    parameter int CFG_W = 16
);
    logic             BusMode;
    logic [11:0]      Addr;
    logic             Sel;
    logic [CFG_W-1:0] DataIn;
    logic [CFG_W-1:0] DataOut;
    logic             Rd_DS;
    logic             Wr_RW;
    logic             Rdy_Dtack;

    modport master (
        output BusMode, Addr, Sel, DataIn, Rd_DS, Wr_RW,
        input  DataOut, Rdy_Dtack
    );

    modport slave (
        input  BusMode, Addr, Sel, DataIn, Rd_DS, Wr_RW,
        output DataOut, Rdy_Dtack
    );
endinterface

// File: rtl/cpu_lut_slave.sv
// CPU-side slave owning the VPI lookup table; one wait state per access,
// plus a registered read port for the receive-side cell router.
module cpu_lut_slave #(
    parameter int NumTx = 4,
    parameter int CFG_W = NumTx + 12,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    cpu_lut_slave_if.slave   bus,
    input  logic [7:0]       lut_rd_addr,
    output logic [CFG_W-1:0] lut_rd_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic             is_rd_q, is_rd_d;
    logic [11:0]      addr_q, addr_d;
    logic [CFG_W-1:0] wdata_q, wdata_d;
    logic [CFG_W-1:0] dout_q, dout_d;
    logic [CFG_W-1:0] lut_q, lut_d;
    logic             rdy_q, rdy_d;
    logic [CFG_W-1:0] table_q [DEPTH];
    logic [CFG_W-1:0] table_d [DEPTH];

    function automatic logic req_valid(input logic mode, input logic sel_n,
                                       input logic rd_ds, input logic wr_rw);
        if (sel_n) begin
            req_valid = 1'b0;
        end else if (mode) begin
            // Intel: exactly one strobe low; both low is illegal
            req_valid = rd_ds ^ wr_rw;
        end else begin
            req_valid = ~rd_ds;
        end
    endfunction

    function automatic logic req_is_read(input logic mode, input logic rd_ds,
                                         input logic wr_rw);
        if (mode) begin
            req_is_read = ~rd_ds;
        end else begin
            req_is_read = wr_rw;
        end
    endfunction

    function automatic logic strobe_released(input logic mode, input logic sel_n,
                                             input logic rd_ds, input logic wr_rw);
        if (mode) begin
            strobe_released = sel_n | (rd_ds & wr_rw);
        end else begin
            strobe_released = sel_n | rd_ds;
        end
    endfunction

    function automatic logic in_table(input logic [11:0] addr);
        in_table = (addr[11:8] == 4'h0) && (int'(addr[7:0]) < DEPTH);
    endfunction

    // Reserved bits between FWD and VPI are stored as zero.
    function automatic logic [CFG_W-1:0] pack_cfg(input logic [NumTx-1:0] fwd,
                                                  input logic [11:0] vpi);
        pack_cfg                    = '0;
        pack_cfg[CFG_W-1 -: NumTx]  = fwd;
        pack_cfg[11:0]              = vpi;
    endfunction

    // Next-state, table update and output computation.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        is_rd_d = is_rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        rdy_d   = rdy_q;
        table_d = table_q;

        case (state_q)
            IDLE: begin
                if (req_valid(bus.BusMode, bus.Sel, bus.Rd_DS, bus.Wr_RW)) begin
                    mode_d  = bus.BusMode;
                    is_rd_d = req_is_read(bus.BusMode, bus.Rd_DS, bus.Wr_RW);
                    addr_d  = bus.Addr;
                    wdata_d = bus.DataIn;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // A request that vanished or changed direction is aborted silently.
                if (req_valid(mode_q, bus.Sel, bus.Rd_DS, bus.Wr_RW) &&
                    (req_is_read(mode_q, bus.Rd_DS, bus.Wr_RW) == is_rd_q)) begin
                    if (is_rd_q) begin
                        dout_d = in_table(addr_q) ? table_q[addr_q[7:0]] : '0;
                    end else if (in_table(addr_q)) begin
                        table_d[addr_q[7:0]] = pack_cfg(wdata_q[CFG_W-1 -: NumTx],
                                                        wdata_q[11:0]);
                    end else begin
                        table_d = table_q;
                    end
                    rdy_d   = 1'b0;
                    state_d = ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (strobe_released(mode_q, bus.Sel, bus.Rd_DS, bus.Wr_RW)) begin
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    rdy_d   = 1'b0;
                    state_d = ACK;
                end
            end
            default: begin
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
        endcase

        if (int'(lut_rd_addr) < DEPTH) begin
            lut_d = table_q[lut_rd_addr];
        end else begin
            lut_d = '0;
        end
    end

    // State, latched request, table and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            is_rd_q <= 1'b0;
            addr_q  <= 12'h000;
            wdata_q <= '0;
            dout_q  <= '0;
            lut_q   <= '0;
            rdy_q   <= 1'b1;
            table_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            is_rd_q <= is_rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            lut_q   <= lut_d;
            rdy_q   <= rdy_d;
            table_q <= table_d;
        end
    end

    assign bus.DataOut   = dout_q;
    assign bus.Rdy_Dtack = rdy_q;
    assign lut_rd_data   = lut_q;

endmodule

// File: doc/cpu_lut_slave.md
# cpu_lut_slave

CPU-side bus slave of the ATM switch core: consumes the CPU bus (peripheral view of the cell-configuration bus) and owns the VPI lookup table of `CellCfgType` entries (forward mask FWD, new VPI). Decodes Intel-style (Rd/Wr/Rdy) and Motorola-style (DS/RW/Dtack) cycles, with a wait-state handshake. Also gives the receive-side cell router a registered read port into the same table.

## Interface
- `NumTx`, default 4: transmit ports; FWD width.
- `CFG_W`, default NumTx+12: packed `CellCfgType` width, FWD in MSBs, VPI[11:0] in LSBs.
- `DEPTH`, default 256: table entries, indexed by Addr[7:0].

Ports:
- `clk` input 1: single clock.
- `rst` input 1: asynchronous, active-high reset.
- `BusMode` input 1: 1 = Intel, 0 = Motorola.
- `Addr` input 12: CPU word address.
- `Sel` input 1: chip select, active low.
- `DataIn` input CFG_W: write data.
- `DataOut` output CFG_W: read data.
- `Rd_DS` input 1: Intel Rd_n / Motorola DS_n, active low.
- `Wr_RW` input 1: Intel Wr_n (active low) / Motorola R/W_n (1 = read).
- `Rdy_Dtack` output 1: Intel Rdy_n / Motorola Dtack_n, active low.
- `lut_rd_addr` input 8: router lookup index (cell VPI[7:0]).
- `lut_rd_data` output CFG_W: router lookup result.

## Operation
- Table: DEPTH x CFG_W flops, all cleared to 0 by reset.
- Request decode:
  - Intel: Sel=0 and exactly one of Rd_DS/Wr_RW low. Rd low = read, Wr low = write. Both low = illegal; ignored, no ack.
  - Motorola: Sel=0 and Rd_DS=0; direction = Wr_RW (1 read, 0 write).
- Map: Addr[11:8]==0 is the table. Anything else is unmapped: write discarded, read returns 0. The handshake still completes.
- FSM states: IDLE, ACCESS, ACK.
  - IDLE: on a valid request, latch BusMode, direction, Addr and DataIn; go to ACCESS.
  - ACCESS (one wait state): re-check the request with the latched mode.
    - Still valid: perform the write, or capture read data into DataOut; go to ACK.
    - Withdrawn: abort with no write and no ack; go to IDLE.
  - ACK: drive Rdy_Dtack=0 and hold DataOut. When the strobe is released (Sel=1, or the strobe(s) inactive per latched mode), go to IDLE; Rdy_Dtack returns to 1 on that edge.
- BusMode, Addr and DataIn changes after IDLE are ignored until the FSM is back in IDLE.
- A new request needs a return to IDLE: at least one cycle with the strobe inactive between accesses.
- Router port: lut_rd_data <= table[lut_rd_addr] every cycle. Unaffected by the CPU FSM.

## Timing
- Reset values: Rdy_Dtack=1, DataOut=0, lut_rd_data=0, FSM=IDLE, table all 0. Reset mid-cycle drops the transaction; a write not yet committed in ACCESS is lost.
- Request sampled at edge E0 -> ACCESS. Write commits at E1; Rdy_Dtack=0 and DataOut valid after E1. Rdy_Dtack=0 holds through the edge that samples the release, then goes 1.
- Minimum transaction: strobe low 2 cycles -> ack visible from cycle 2.
- DataOut keeps its last read value after ack. Writes do not change DataOut.
- Router read latency: 1 cycle.
- CPU write and router read of the same index on the same edge: the router sees old data; new data appears the following cycle.

## Test plan
- After reset, Motorola read of Addr=0x005 -> Rdy_Dtack=0 two cycles after strobe, DataOut=0.
- Intel write FWD=4'b1010, VPI=12'h123 to Addr=0x07F. Then Intel read of 0x07F -> DataOut=16'hA123. The following cycle, lut_rd_addr=8'h7F gives lut_rd_data=16'hA123.
- Motorola write 16'h5FFF to Addr=0x1FF (unmapped) -> acked. Read of 0x0FF still returns 0; read of 0x1FF returns 0.
- Strobe dropped after one cycle (abort in ACCESS) with write data 16'h1234 to 0x010 -> no ack, table[0x10] remains 0.
- Intel Rd and Wr both low -> FSM stays IDLE, Rdy_Dtack stays 1. Flip BusMode mid-ACK -> ack holds until the latched-mode release.
- Router reads 0x20 on the same edge a CPU write of 16'h3456 commits there -> old value, then 16'h3456 next cycle. Assert rst during ACK -> Rdy_Dtack=1 immediately, table cleared.
